// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_e : arbiter FSM states (no transaction / fetch owns bus / data owns bus)
//   FETCH_SIZE  : access size code driven on the bus for every instruction fetch
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2
  } arb_state_e;

  localparam logic [2:0] FETCH_SIZE = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Busy-cycle watchdog for the memory port arbiter.
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   clr       : hold the count at zero (bus idle)
//   en        : a busy cycle without bus_ack; advances the count
//   expired   : this busy cycle is the TIMEOUT-th one without an ack
// TIMEOUT = 0 disables the watchdog (expired never asserts).
module arb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT < 32'd1) ? 1 : $clog2(TIMEOUT + 32'd1);
  // The count starts at zero in the first busy cycle, so the TIMEOUT-th busy
  // cycle is the one that observes TIMEOUT-1.
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 32'd0) ? (TIMEOUT - 32'd1) : 32'd0);

  logic [CNT_W-1:0] cnt_r;

  // Busy-cycle count; saturates at LAST because the FSM leaves the busy state there.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // An ack in the limit cycle drops en, so a real completion beats the timeout.
  assign expired = (TIMEOUT != 32'd0) ? (en & (cnt_r == LAST)) : 1'b0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory bus port between instruction fetch (if_*) and the
// data stage (mem_*). One transaction outstanding at a time; data wins by
// default but a fetch waiting through a data transaction is served next.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   if_req/if_addr           : fetch request, held until if_resp_valid
//   if_resp_valid/err/rdata  : fetch completion (combinational with bus_ack)
//   mem_req/addr/wen/wdata/strb/size : data request, held until mem_resp_valid
//   mem_resp_valid/err/rdata : data completion
//   bus_req + bus_* fields   : registered transaction toward memory
//   bus_ack/err/rdata        : memory completion pulse, error, read data
//   stall_from_if_o/_mem_o   : per-stage stall requests to the pipeline
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic                if_resp_err,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_wen,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_strb,
  input  logic [2:0]          mem_size,
  output logic                mem_resp_valid,
  output logic                mem_resp_err,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_req,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_wen,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_strb,
  output logic [2:0]          bus_size,
  input  logic                bus_ack,
  input  logic                bus_err,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                stall_from_if_o,
  output logic                stall_from_mem_o
);

  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_e state_r;
  arb_state_e state_s;
  logic       fetch_owed_r;
  logic       fetch_owed_s;
  logic       grant_mem_s;
  logic       grant_if_s;
  logic       busy_s;
  logic       cnt_clr_s;
  logic       cnt_en_s;
  logic       timeout_s;

  // Watchdog control kept outside the FSM block so expired never feeds back into it.
  assign busy_s    = (state_r != IDLE);
  assign cnt_clr_s = ~busy_s;
  assign cnt_en_s  = busy_s & ~bus_ack;
  assign bus_req   = busy_s;

  arb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr_s),
    .en      (cnt_en_s),
    .expired (timeout_s)
  );

  // State, anti-starvation flag and transaction fields captured at grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      fetch_owed_r <= 1'b0;
      bus_addr     <= {ADDR_W{1'b0}};
      bus_wen      <= 1'b0;
      bus_wdata    <= {DATA_W{1'b0}};
      bus_strb     <= {STRB_W{1'b0}};
      bus_size     <= 3'b000;
    end else begin
      state_r      <= state_s;
      fetch_owed_r <= fetch_owed_s;
      if (grant_mem_s) begin
        bus_addr  <= mem_addr;
        bus_wen   <= mem_wen;
        bus_wdata <= mem_wdata;
        bus_strb  <= mem_strb;
        bus_size  <= mem_size;
      end else if (grant_if_s) begin
        bus_addr  <= if_addr;
        bus_wen   <= 1'b0;
        bus_wdata <= {DATA_W{1'b0}};
        bus_strb  <= {STRB_W{1'b0}};
        bus_size  <= FETCH_SIZE;
      end else begin
        bus_addr  <= bus_addr;
        bus_wen   <= bus_wen;
        bus_wdata <= bus_wdata;
        bus_strb  <= bus_strb;
        bus_size  <= bus_size;
      end
    end
  end

  // Grant decision, completion routing to the owning requester, stall requests.
  always_comb begin
    state_s        = state_r;
    fetch_owed_s   = fetch_owed_r;
    grant_mem_s    = 1'b0;
    grant_if_s     = 1'b0;
    if_resp_valid  = 1'b0;
    if_resp_err    = 1'b0;
    if_rdata       = {DATA_W{1'b0}};
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    mem_rdata      = {DATA_W{1'b0}};

    case (state_r)
      IDLE: begin
        // Data wins unless a fetch is owed a turn.
        if (mem_req && (!if_req || !fetch_owed_r)) begin
          state_s     = MEM_BUSY;
          grant_mem_s = 1'b1;
        end else if (if_req) begin
          state_s      = IF_BUSY;
          grant_if_s   = 1'b1;
          fetch_owed_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      IF_BUSY: begin
        if (bus_ack || timeout_s) begin
          state_s       = IDLE;
          if_resp_valid = 1'b1;
          if_resp_err   = timeout_s | bus_err;
          if_rdata      = bus_rdata;
        end else begin
          state_s = IF_BUSY;
        end
      end
      MEM_BUSY: begin
        if (bus_ack || timeout_s) begin
          state_s        = IDLE;
          mem_resp_valid = 1'b1;
          mem_resp_err   = timeout_s | bus_err;
          mem_rdata      = bus_rdata;
          // A fetch that waited through this transaction goes next.
          if (if_req) begin
            fetch_owed_s = 1'b1;
          end else begin
            fetch_owed_s = fetch_owed_r;
          end
        end else begin
          state_s = MEM_BUSY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    stall_from_if_o  = if_req & ~if_resp_valid;
    stall_from_mem_o = mem_req & ~mem_resp_valid;
  end

endmodule
